// File: rtl/polar_gsub_dec_if.sv
// Job/result bundle between the parent SC stage and polar_gsub_dec.
// The slave side is the decoder; the master side is the parent stage.
interface polar_gsub_dec_if #(
    parameter int BW    = 7,
    parameter int LOG_M = 2
);
    localparam int M = 1 << LOG_M;

    logic            in_valid_i;
    logic            in_ready_o;
    logic            mode_i;
    logic [M*BW-1:0] llr_a_i;
    logic [M*BW-1:0] llr_b_i;
    logic [M-1:0]    psum_i;
    logic [M-1:0]    frozen_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [M-1:0]    u_o;
    logic [M-1:0]    x_o;

    modport slave (
        input  in_valid_i, mode_i, llr_a_i, llr_b_i, psum_i, frozen_i, out_ready_i,
        output in_ready_o, out_valid_o, u_o, x_o
    );

    modport master (
        output in_valid_i, mode_i, llr_a_i, llr_b_i, psum_i, frozen_i, out_ready_i,
        input  in_ready_o, out_valid_o, u_o, x_o
    );
endinterface

// File: rtl/polar_gsub_dec.sv
// G/F entry stage over 2*M LLRs, then serial SC decode of an M-leaf subtree, one leaf per cycle.
// Latency: M+2 cycles accept-to-valid; 2 for all-frozen jobs when POLAR_RATE0_SKIP_EN is defined.
// Backpressure: result held in DONE until out_ready_i; in_ready_o is low whenever not IDLE.
module polar_gsub_dec #(
    parameter int BW    = 7,
    parameter int LOG_M = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    polar_gsub_dec_if.slave  bus
);
    localparam int M    = 1 << LOG_M;
    localparam int MAXI = (1 << (BW - 1)) - 1;
    localparam logic signed [BW:0] MAXP = (BW + 1)'(MAXI);
    localparam logic signed [BW:0] MAXN = -MAXP;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] DEC   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [LOG_M-1:0]     idx;
    logic                 mode_q;
    logic [M*BW-1:0]      a_q;
    logic [M*BW-1:0]      b_q;
    logic [M-1:0]         psum_q;
    logic [M-1:0]         frozen_q;
    logic [M-1:0]         u_q;
    logic signed [BW-1:0] l_q [M];
    logic signed [BW-1:0] leaf;
    logic                 leaf_bit;

    function automatic logic signed [BW:0] ext(input logic signed [BW-1:0] v);
        return {v[BW-1], v};
    endfunction

    function automatic logic signed [BW-1:0] sat(input logic signed [BW:0] v);
        logic signed [BW:0] r;
        r = v;
        if (v > MAXP) r = MAXP;
        if (v < MAXN) r = MAXN;
        return r[BW-1:0];
    endfunction

    function automatic logic signed [BW-1:0] f_fn(input logic signed [BW-1:0] a,
                                                  input logic signed [BW-1:0] b);
        logic signed [BW:0] ma;
        logic signed [BW:0] mb;
        logic signed [BW:0] m;
        ma = a[BW-1] ? -ext(a) : ext(a);
        mb = b[BW-1] ? -ext(b) : ext(b);
        if (ma > MAXP) ma = MAXP;
        if (mb > MAXP) mb = MAXP;
        m = (ma < mb) ? ma : mb;
        if (a[BW-1] ^ b[BW-1]) m = -m;
        return m[BW-1:0];
    endfunction

    function automatic logic signed [BW-1:0] g_fn(input logic signed [BW-1:0] a,
                                                  input logic signed [BW-1:0] b,
                                                  input logic s);
        return sat(s ? (ext(b) - ext(a)) : (ext(b) + ext(a)));
    endfunction

    // Natural-order Arikan butterfly; zero-padded upper lanes leave the lower half's encoding intact.
    function automatic logic [M-1:0] encode(input logic [M-1:0] v);
        logic [M-1:0] x;
        x = v;
        for (int s = 1; s < M; s = s * 2)
            for (int j = 0; j < M; j++)
                if ((j & s) == 0 && j + s < M) x[j] = x[j] ^ x[j + s];
        return x;
    endfunction

    // Walk root to leaf idx: the idx bit at each level picks f (left) or g (right, with
    // partial sums re-encoded from the already decided left sibling).
    always_comb begin
        logic signed [BW-1:0] lv [M];
        logic [M-1:0]         sub;
        logic [M-1:0]         ps;
        logic [LOG_M-1:0]     pos;
        logic [LOG_M-1:0]     pj;
        int                   half;
        int                   base;
        for (int k = 0; k < M; k++) lv[k] = l_q[k];
        for (int d = 0; d < LOG_M; d++) begin
            half = M >> (d + 1);
            base = (int'(idx) >> (LOG_M - d)) << (LOG_M - d);
            sub  = '0;
            for (int i = 0; i < M; i++) begin
                pos = LOG_M'(base + i);
                if (i < half) sub[i] = u_q[pos];
            end
            ps = encode(sub);
            for (int j = 0; j < M; j++) begin
                pj = LOG_M'(j + half);
                if (j < half)
                    lv[j] = idx[LOG_M-1-d] ? g_fn(lv[j], lv[pj], ps[j]) : f_fn(lv[j], lv[pj]);
            end
        end
        leaf = lv[0];
    end

    assign leaf_bit = ~frozen_q[idx] & leaf[BW-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            psum_q   <= '0;
            frozen_q <= '0;
            u_q      <= '0;
            for (int k = 0; k < M; k++) l_q[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        mode_q   <= bus.mode_i;
                        a_q      <= bus.llr_a_i;
                        b_q      <= bus.llr_b_i;
                        psum_q   <= bus.psum_i;
                        frozen_q <= bus.frozen_i;
                        u_q      <= '0;
                        state    <= ENTRY;
                    end
                end
                ENTRY: begin
                    for (int k = 0; k < M; k++)
                        l_q[k] <= mode_q ? g_fn(a_q[k*BW +: BW], b_q[k*BW +: BW], psum_q[k])
                                         : f_fn(a_q[k*BW +: BW], b_q[k*BW +: BW]);
                    idx   <= '0;
                    state <= DEC;
`ifdef POLAR_RATE0_SKIP_EN
                    if (&frozen_q) state <= DONE;
`endif
                end
                DEC: begin
                    u_q[idx] <= leaf_bit;
                    idx      <= idx + LOG_M'(1);
                    if (idx == LOG_M'(M - 1)) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = (state == DONE);
    assign bus.u_o         = u_q;
    assign bus.x_o         = encode(u_q);
endmodule

// File: tb/tb_polar_gsub_dec.sv
// Directed and random jobs for polar_gsub_dec (BW=7, M=4) against a node-recursive SC model.
module tb_polar_gsub_dec;
    localparam int BW = 7;
    localparam int LOG_M = 2;
    localparam int M = 4;
`ifdef POLAR_RATE0_SKIP_EN
    localparam int LAT_R0 = 2;
`else
    localparam int LAT_R0 = 6;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    polar_gsub_dec_if #(.BW(BW), .LOG_M(LOG_M)) bus ();
    polar_gsub_dec #(.BW(BW), .LOG_M(LOG_M)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    int         av [M];
    int         bv [M];
    logic       md;
    logic [M-1:0] ps, fr, eu, ex, bu, bx;
    int         lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 63) ? 63 : ((v < -63) ? -63 : v);
    endfunction

    function automatic int fmin(input int a, input int b);
        int ma, mb, m;
        ma = sat(a < 0 ? -a : a);
        mb = sat(b < 0 ? -b : b);
        m  = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    function automatic int gsum(input int a, input int b, input logic s);
        return sat(s ? b - a : b + a);
    endfunction

    // Two-leaf node: left leaf from f, right leaf from g with the left decision.
    task automatic dec2(input int l0, input int l1, input logic f0, input logic f1,
                        output logic u0, output logic u1);
        u0 = f0 ? 1'b0 : (fmin(l0, l1) < 0);
        u1 = f1 ? 1'b0 : (gsum(l0, l1, u0) < 0);
    endtask

    task automatic model();
        int l [M];
        logic u0, u1, u2, u3;
        for (int k = 0; k < M; k++) l[k] = md ? gsum(av[k], bv[k], ps[k]) : fmin(av[k], bv[k]);
        dec2(fmin(l[0], l[2]), fmin(l[1], l[3]), fr[0], fr[1], u0, u1);
        dec2(gsum(l[0], l[2], u0 ^ u1), gsum(l[1], l[3], u1), fr[2], fr[3], u2, u3);
        eu = {u3, u2, u1, u0};
        ex = {u3, u2 ^ u3, u1 ^ u3, u0 ^ u1 ^ u2 ^ u3};
    endtask

    task automatic drive_job();
        for (int k = 0; k < M; k++) begin
            bus.llr_a_i[k*BW +: BW] = BW'(av[k]);
            bus.llr_b_i[k*BW +: BW] = BW'(bv[k]);
        end
        bus.mode_i   = md;
        bus.psum_i   = ps;
        bus.frozen_i = fr;
    endtask

    // Returns one cycle after the accepting edge (cycle 1).
    task automatic send();
        int t;
        drive_job();
        bus.in_valid_i = 1'b1;
        t = 0;
        while (bus.in_ready_o !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("accept_wait", 32'(t < 50), 32'd1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 1;
        while (bus.out_valid_o !== 1'b1 && l < 100) begin @(posedge clk); #1; l++; end
    endtask

    task automatic rand_job();
        for (int k = 0; k < M; k++) begin
            av[k] = int'($urandom_range(0, 127)) - 64;
            bv[k] = int'($urandom_range(0, 127)) - 64;
        end
        md = 1'($urandom_range(0, 1));
        ps = 4'($urandom_range(0, 15));
        fr = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; bus.mode_i = 1'b0;
        bus.llr_a_i = '0; bus.llr_b_i = '0; bus.psum_i = '0; bus.frozen_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_u", 32'(bus.u_o), 32'd0);
        check("rst_x", 32'(bus.x_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // G entry example
        av = '{10, -5, 3, 63}; bv = '{20, 20, -63, 63}; md = 1'b1; ps = 4'b0110; fr = 4'b0000;
        model(); send(); wait_out(lat);
        check("g_latency", 32'(lat), 32'd6);
        check("g_u", 32'(bus.u_o), 32'b0101);
        check("g_x", 32'(bus.x_o), 32'b0100);
        check("g_u_model", 32'(bus.u_o), 32'(eu));
        @(posedge clk); #1;

        // F entry, same LLRs
        md = 1'b0;
        model(); send(); wait_out(lat);
        check("f_latency", 32'(lat), 32'd6);
        check("f_u", 32'(bus.u_o), 32'b0110);
        check("f_x", 32'(bus.x_o), 32'b0110);
        check("f_x_model", 32'(bus.x_o), 32'(ex));
        @(posedge clk); #1;

        // All frozen
        md = 1'b1; fr = 4'b1111;
        send(); wait_out(lat);
        check("r0_latency", 32'(lat), 32'(LAT_R0));
        check("r0_u", 32'(bus.u_o), 32'd0);
        check("r0_x", 32'(bus.x_o), 32'd0);
        @(posedge clk); #1;

        // Saturation of -64 + -64, only leaf 3 free
        av = '{-64, -64, -64, -64}; bv = '{-64, -64, -64, -64}; md = 1'b1; ps = 4'b0000; fr = 4'b0111;
        send(); wait_out(lat);
        check("sat_u", 32'(bus.u_o), 32'b1000);
        check("sat_x", 32'(bus.x_o), 32'b1111);
        @(posedge clk); #1;

        // Back-pressure with the next job pending
        av = '{10, -5, 3, 63}; bv = '{20, 20, -63, 63}; md = 1'b1; ps = 4'b0110; fr = 4'b0000;
        model(); bu = eu; bx = ex;
        bus.out_ready_i = 1'b0;
        send(); wait_out(lat);
        check("bp_latency", 32'(lat), 32'd6);
        av = '{-30, 7, 44, -2}; bv = '{12, -60, 5, 19}; md = 1'b0; ps = 4'b1010; fr = 4'b0001;
        model(); drive_job(); bus.in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_u_hold", 32'(bus.u_o), 32'(bu));
            check("bp_x_hold", 32'(bus.x_o), 32'(bx));
            check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        check("b2b_idle_ready", 32'(bus.in_ready_o), 32'd1);
        check("b2b_idle_valid", 32'(bus.out_valid_o), 32'd0);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        check("b2b_accepted", 32'(bus.in_ready_o), 32'd0);
        wait_out(lat);
        check("b2b_latency", 32'(lat), 32'd6);
        check("b2b_u", 32'(bus.u_o), 32'(eu));
        check("b2b_x", 32'(bus.x_o), 32'(ex));
        @(posedge clk); #1;

        // Reset during the second DEC cycle drops the job
        rand_job(); fr = 4'b0000;
        send();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("mrst_u", 32'(bus.u_o), 32'd0);
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid_o === 1'b1) hits++;
        end
        check("mrst_no_output", 32'(hits), 32'd0);

        // Randomized jobs, random consumer stalls
        for (int n = 0; n < 40; n++) begin
            rand_job(); model(); send(); wait_out(lat);
            check("rnd_latency", 32'(lat), (fr == 4'hF) ? 32'(LAT_R0) : 32'd6);
            check("rnd_u", 32'(bus.u_o), 32'(eu));
            check("rnd_x", 32'(bus.x_o), 32'(ex));
            bus.out_ready_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            check("rnd_x_hold", 32'(bus.x_o), 32'(ex));
            bus.out_ready_i = 1'b1;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/polar_gsub_dec.md
Name: polar_gsub_dec

Overview:
- Parametrised successor of the fixed radix-4 G accumulator.
- Applies one entry stage to 2*M channel LLRs; the entry stage is either G (with partial sums) or F, selected per job.
- Then decodes the resulting M-leaf subtree serially with successive cancellation, one leaf per cycle.
- Returns the decoded bits and re-encoded partial sums to the parent decoder stage over a valid/ready handshake.

Parameters:
- BW, 7, LLR width in bits, two's complement.
- LOG_M, 2, log2 of subtree size. M = 2**LOG_M, legal range 1..4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  job valid.
- in_ready_o  out  1  block can accept a job.
- mode_i  in  1  entry stage: 0 = F, 1 = G.
- llr_a_i  in  M*BW  first LLR of each pair; lane k at bits [k*BW +: BW].
- llr_b_i  in  M*BW  second LLR of each pair.
- psum_i  in  M  partial sums for the G entry stage; ignored when mode_i = 0.
- frozen_i  in  M  frozen mask, bit i = leaf i.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- u_o  out  M  decoded leaf bits.
- x_o  out  M  re-encoded partial sums of u_o.

Behaviour:
- Reset (synchronous, rst_i = 1 at a clock edge):
  - State goes to IDLE.
  - in_ready_o = 1, out_valid_o = 0, u_o = 0, x_o = 0.
  - Internal LLR and bit registers are cleared.
  - Reset mid-job drops the job; no output is produced for it.
- FSM states: IDLE -> ENTRY -> DEC -> DONE -> IDLE.
  - IDLE: in_ready_o = 1. On in_valid_i & in_ready_o, capture all inputs and go to ENTRY.
  - ENTRY: one cycle. Compute the M entry LLRs per lane k and register them.
    - G mode: L[k] = sat(b[k] + a[k]) if psum[k] = 0, else sat(b[k] - a[k]).
    - F mode: L[k] = sign(a)*sign(b)*min(|a|,|b|).
    - Go to DEC with leaf index idx = 0.
  - DEC: M cycles. Each cycle, combinationally evaluate the SC f/g tree over L for leaf idx, using already decided bits u[0..idx-1].
    - Tree pairing: lane j is paired with lane j + half at every level.
    - Leaf decision: u[idx] = 0 if frozen[idx]; otherwise 1 iff leaf LLR < 0. LLR = 0 decides 0.
    - idx increments. After idx = M-1, go to DONE.
  - DONE: out_valid_o = 1 while u_o and x_o are held stable. On out_ready_i go to IDLE.
- Latency: acceptance at cycle 0 puts out_valid_o high in cycle M+2, with out_ready_i not back-pressuring.
- Throughput: one job per M+3 cycles minimum.
- in_ready_o is 0 in every state except IDLE, so no job is accepted while busy.
- Arithmetic:
  - All f/g results saturate symmetrically to +/-(2**(BW-1)-1).
  - |-2**(BW-1)| clips to 2**(BW-1)-1.
  - Internal sums use BW+1 bits before saturation.
- x_o = u * G_M (Arikan kernel, natural order). Recursively: x = [xL ^ xR, xR], where xL is the encoding of the left half of u and xR of the right half.
- x_o is only meaningful while out_valid_o = 1; it is held until the handshake.
- LOG_M = 1: the tree is a single f/g pair.
- Back-to-back: in_valid_i held high through DONE is accepted in the cycle after the out handshake, i.e. the first IDLE cycle.

Optional Feature:
- Macro: POLAR_RATE0_SKIP_EN.
- Defined: if the captured frozen_i is all ones, ENTRY goes directly to DONE with u = x = 0. out_valid_o rises in cycle 2 after acceptance.
- Not defined: all-frozen jobs take the full M-cycle DEC pass. Output is identical (all zeros); only latency differs.

Test Plan:
- BW=7, LOG_M=2, G mode:
  - Stimulus: a = [10,-5,3,63], b = [20,20,-63,63], psum = [0,1,1,0], frozen = 0000.
  - Response: entry L = [30,25,-63,63]; u_o = 1010 (u0=1,u1=0,u2=1,u3=0); x_o = [0,0,1,0]; out_valid_o in cycle 6.
- F mode, same a/b, frozen = 0000:
  - Response: L = [10,-5,-3,63]; out_valid_o in cycle 6.
  - Compare u_o and x_o against a bit-exact reference model.
- Frozen handling:
  - Stimulus: frozen = 1111.
  - Response: u_o = x_o = 0; out_valid_o at cycle 6 without the macro, cycle 2 with it.
- Saturation:
  - Stimulus: G mode, a = -64, b = -64, psum = 0.
  - Response: L = -63 on that lane. With frozen = 1110, u3 = 1.
- Back-pressure:
  - Stimulus: hold out_ready_i = 0 for 5 cycles after out_valid_o rises.
  - Response: u_o and x_o stay stable; in_ready_o stays 0; the next job is accepted one cycle after the handshake.
- Mid-job reset:
  - Stimulus: assert rst_i during DEC cycle 2.
  - Response: next cycle out_valid_o = 0 and in_ready_o = 1. A fresh job then decodes correctly.
